// File: rtl/pipelined_adder_n_bit.sv
// -----------------------------------------------------------------------------
// pipelined_adder_n_bit
//
// Parametrised pipelined integer adder/subtractor. A WIDTH-bit add is split
// into STAGES chunks of CW = WIDTH/STAGES bits. Stage k adds chunk k of the
// operands plus the carry registered by stage k-1, so each stage only has a
// CW-bit ripple in its path. Beats move through the pipeline with a
// valid/ready handshake on both ends. Full throughput is one operation per
// cycle, and up to STAGES operations can be in flight.
//
// Parameters
//   WIDTH   operand/result width (must be a multiple of STAGES)
//   STAGES  pipeline depth, >= 1
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (drops every in-flight beat)
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle (combinational from out_ready)
//   in_a       operand A
//   in_b       operand B
//   in_cin     carry in (add) / borrow in (subtract)
//   in_sub     0 = A+B+cin, 1 = A-B-cin
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   out_sum    result
//   out_cout   raw carry out of the MSB (1 = no borrow when subtracting)
//   out_ovf    signed overflow
//   out_zero   out_sum == 0
// -----------------------------------------------------------------------------
module pipelined_adder_n_bit #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      // RW: operand bits still to be added when entering stage k.
      // SW: result bits completed once stage k has added its chunk.
      localparam int RW = WIDTH - k * CW;
      localparam int SW = (k + 1) * CW;

      logic          src_v_s;
      logic          src_c_s;
      logic [RW-1:0] src_a_s;
      logic [RW-1:0] src_b_s;
      logic [CW:0]   ext_s;
      logic [SW-1:0] nsum_s;
      logic          adv_s;
      logic          load_s;

      logic          valid_r;
      logic          carry_r;
      logic [SW-1:0] sum_r;

      if (k == 0) begin : g_src
        // Subtraction is A + ~B + 1; the incoming borrow flips that +1 off.
        assign src_v_s = in_valid;
        assign src_a_s = in_a;
        assign src_b_s = in_sub ? ~in_b : in_b;
        assign src_c_s = in_cin ^ in_sub;
        assign nsum_s  = ext_s[CW-1:0];
      end else begin : g_src
        assign src_v_s = g_stage[k-1].valid_r;
        assign src_a_s = g_stage[k-1].g_fwd.a_r;
        assign src_b_s = g_stage[k-1].g_fwd.b_r;
        assign src_c_s = g_stage[k-1].carry_r;
        assign nsum_s  = {ext_s[CW-1:0], g_stage[k-1].sum_r};
      end

      // The lowest CW bits of the remaining operands always belong to chunk k.
      assign ext_s  = {1'b0, src_a_s[CW-1:0]} + {1'b0, src_b_s[CW-1:0]}
                    + {{CW{1'b0}}, src_c_s};
      assign load_s = !valid_r || adv_s;

      // Stage register: valid follows its source whenever the stage may load;
      // data only moves with a valid beat so bubbles never disturb held data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_r <= 1'b0;
          carry_r <= 1'b0;
          sum_r   <= {SW{1'b0}};
        end else begin
          if (load_s) begin
            valid_r <= src_v_s;
          end
          if (load_s && src_v_s) begin
            carry_r <= ext_s[CW];
            sum_r   <= nsum_s;
          end
        end
      end

      if (k == LAST) begin : g_out
        logic msb_cin_s;
        logic zero_r;
        logic ovf_r;

        assign adv_s = valid_r && out_ready;

        // Carry into the MSB recovered from the MSB sum bit and its operands.
        assign msb_cin_s = ext_s[CW-1] ^ src_a_s[CW-1] ^ src_b_s[CW-1];

        // Result flags are produced together with the final chunk.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
          end else if (load_s && src_v_s) begin
            zero_r <= (nsum_s == {SW{1'b0}});
            ovf_r  <= msb_cin_s ^ ext_s[CW];
          end
        end
      end else begin : g_fwd
        localparam int UW = RW - CW;
        logic [UW-1:0] a_r;
        logic [UW-1:0] b_r;

        // A stage advances when the next one is empty or is itself advancing.
        assign adv_s = valid_r && (!g_stage[k+1].valid_r || g_stage[k+1].adv_s);

        // Unconsumed upper operand chunks travel alongside the partial sum.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_r <= {UW{1'b0}};
            b_r <= {UW{1'b0}};
          end else if (load_s && src_v_s) begin
            a_r <= src_a_s[RW-1:CW];
            b_r <= src_b_s[RW-1:CW];
          end
        end
      end
    end
  endgenerate

  assign in_ready  = g_stage[0].load_s;
  assign out_valid = g_stage[LAST].valid_r;
  assign out_sum   = g_stage[LAST].sum_r;
  assign out_cout  = g_stage[LAST].carry_r;
  assign out_ovf   = g_stage[LAST].g_out.ovf_r;
  assign out_zero  = g_stage[LAST].g_out.zero_r;

endmodule

// File: tb/tb_pipelined_adder_n_bit.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pipelined_adder_n_bit. Three instances are exercised:
// 32-bit/4 stages (directed, streaming, backpressure, reset), 8-bit/1 stage and
// 64-bit/8 stages (streaming). A scoreboard per instance stores the expected
// result of every accepted beat and compares it when the beat leaves.
// -----------------------------------------------------------------------------
module tb_pipelined_adder_n_bit;

  logic clk;
  logic rst_n;

  int n_assert = 0;
  int n_fail   = 0;

  logic        p32_in_valid, p32_in_ready, p32_in_cin, p32_in_sub;
  logic        p32_out_valid, p32_out_ready, p32_out_cout, p32_out_ovf, p32_out_zero;
  logic [31:0] p32_in_a, p32_in_b, p32_out_sum;

  logic        p8_in_valid, p8_in_ready, p8_in_cin, p8_in_sub;
  logic        p8_out_valid, p8_out_ready, p8_out_cout, p8_out_ovf, p8_out_zero;
  logic [7:0]  p8_in_a, p8_in_b, p8_out_sum;

  logic        p64_in_valid, p64_in_ready, p64_in_cin, p64_in_sub;
  logic        p64_out_valid, p64_out_ready, p64_out_cout, p64_out_ovf, p64_out_zero;
  logic [63:0] p64_in_a, p64_in_b, p64_out_sum;

  logic [66:0] q32[$];
  logic [66:0] q8[$];
  logic [66:0] q64[$];
  int p32_nout = 0;
  int p8_nout  = 0;
  int p64_nout = 0;

  logic [63:0] ra, rb;
  logic        rcin, rsub;
  logic [1:0]  rsel;
  logic [31:0] held;
  int          stall, acc, s32, s8, s64;

  pipelined_adder_n_bit #(.WIDTH(32), .STAGES(4)) u_p32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(p32_in_valid), .in_ready(p32_in_ready),
    .in_a(p32_in_a), .in_b(p32_in_b), .in_cin(p32_in_cin), .in_sub(p32_in_sub),
    .out_valid(p32_out_valid), .out_ready(p32_out_ready),
    .out_sum(p32_out_sum), .out_cout(p32_out_cout), .out_ovf(p32_out_ovf), .out_zero(p32_out_zero)
  );

  pipelined_adder_n_bit #(.WIDTH(8), .STAGES(1)) u_p8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(p8_in_valid), .in_ready(p8_in_ready),
    .in_a(p8_in_a), .in_b(p8_in_b), .in_cin(p8_in_cin), .in_sub(p8_in_sub),
    .out_valid(p8_out_valid), .out_ready(p8_out_ready),
    .out_sum(p8_out_sum), .out_cout(p8_out_cout), .out_ovf(p8_out_ovf), .out_zero(p8_out_zero)
  );

  pipelined_adder_n_bit #(.WIDTH(64), .STAGES(8)) u_p64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(p64_in_valid), .in_ready(p64_in_ready),
    .in_a(p64_in_a), .in_b(p64_in_b), .in_cin(p64_in_cin), .in_sub(p64_in_sub),
    .out_valid(p64_out_valid), .out_ready(p64_out_ready),
    .out_sum(p64_out_sum), .out_cout(p64_out_cout), .out_ovf(p64_out_ovf), .out_zero(p64_out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width add with the carry taken from bit w, signed overflow
  // from operand/result sign bits. Packed as {sum[63:0], cout, ovf, zero}.
  function automatic logic [66:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] m, am, bm, s;
    logic [64:0] full;
    logic        ovf;
    m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = a & m;
    bm   = (sub ? ~b : b) & m;
    full = {1'b0, am} + {1'b0, bm} + {64'd0, cin ^ sub};
    s    = full[63:0] & m;
    ovf  = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {s, full[w], ovf, s == 64'd0};
  endfunction

  function automatic logic [66:0] r32(input logic [31:0] s, input logic c, input logic o, input logic z);
    return {32'd0, s, c, o, z};
  endfunction

  task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboards: push on accept, pop and compare on release, flush on reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      q32.delete();
    end else begin
      if (p32_out_valid && p32_out_ready) begin
        p32_nout++;
        if (q32.size() == 0) check("p32_unexpected_beat", 67'(1), 67'(0));
        else check("p32_result", {32'd0, p32_out_sum, p32_out_cout, p32_out_ovf, p32_out_zero}, q32.pop_front());
      end
      if (p32_in_valid && p32_in_ready)
        q32.push_back(model(32, {32'd0, p32_in_a}, {32'd0, p32_in_b}, p32_in_cin, p32_in_sub));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete();
    end else begin
      if (p8_out_valid && p8_out_ready) begin
        p8_nout++;
        if (q8.size() == 0) check("p8_unexpected_beat", 67'(1), 67'(0));
        else check("p8_result", {56'd0, p8_out_sum, p8_out_cout, p8_out_ovf, p8_out_zero}, q8.pop_front());
      end
      if (p8_in_valid && p8_in_ready)
        q8.push_back(model(8, {56'd0, p8_in_a}, {56'd0, p8_in_b}, p8_in_cin, p8_in_sub));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q64.delete();
    end else begin
      if (p64_out_valid && p64_out_ready) begin
        p64_nout++;
        if (q64.size() == 0) check("p64_unexpected_beat", 67'(1), 67'(0));
        else check("p64_result", {p64_out_sum, p64_out_cout, p64_out_ovf, p64_out_zero}, q64.pop_front());
      end
      if (p64_in_valid && p64_in_ready)
        q64.push_back(model(64, p64_in_a, p64_in_b, p64_in_cin, p64_in_sub));
    end
  end

  // One directed op on the 32-bit instance: latency and constant expected result.
  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub, input logic [66:0] exp);
    int lat;
    @(posedge clk); #1;
    p32_in_valid = 1'b1; p32_in_a = a; p32_in_b = b; p32_in_cin = cin; p32_in_sub = sub;
    @(negedge clk); #1;
    check($sformatf("%s_ready", tag), 67'(p32_in_ready), 67'(1));
    @(posedge clk); #1;
    p32_in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk); #1;
      if (p32_out_valid) begin
        lat = i;
        break;
      end
    end
    check($sformatf("%s_latency", tag), 67'(lat), 67'(4));
    check(tag, {32'd0, p32_out_sum, p32_out_cout, p32_out_ovf, p32_out_zero}, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    p32_in_valid = 1'b0; p32_in_a = 32'd0; p32_in_b = 32'd0; p32_in_cin = 1'b0; p32_in_sub = 1'b0; p32_out_ready = 1'b1;
    p8_in_valid  = 1'b0; p8_in_a  = 8'd0;  p8_in_b  = 8'd0;  p8_in_cin  = 1'b0; p8_in_sub  = 1'b0; p8_out_ready  = 1'b1;
    p64_in_valid = 1'b0; p64_in_a = 64'd0; p64_in_b = 64'd0; p64_in_cin = 1'b0; p64_in_sub = 1'b0; p64_out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 67'({p32_out_valid, p8_out_valid, p64_out_valid}), 67'(0));
    check("reset_p32_out", {32'd0, p32_out_sum, p32_out_cout, p32_out_ovf, p32_out_zero}, 67'(0));
    check("reset_p64_out", {p64_out_sum, p64_out_cout, p64_out_ovf, p64_out_zero}, 67'(0));
    check("reset_in_ready", 67'({p32_in_ready, p8_in_ready, p64_in_ready}), 67'(3'b111));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_in_ready", 67'({p32_in_ready, p8_in_ready, p64_in_ready}), 67'(3'b111));

    // Directed corner cases
    op32("add_wrap",        32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r32(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    op32("add_ovf",         32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r32(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    op32("add_chunk_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, r32(32'h0001_0001, 1'b0, 1'b0, 1'b0));
    op32("sub_negative",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, r32(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    op32("sub_ovf",         32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, r32(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    op32("sub_borrow_in",   32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, r32(32'h0000_0006, 1'b1, 1'b0, 1'b0));

    // Random stream on all three instances, out_ready held high
    stall = 0;
    s32 = p32_nout; s8 = p8_nout; s64 = p64_nout;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      rsel = 2'($urandom_range(0, 3));
      if (rsel == 2'd0) ra = {64{1'b1}};
      else if (rsel == 2'd1) rb = ~ra;
      else ra = ra;
      rcin = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      p32_in_valid = 1'b1; p32_in_a = ra[31:0]; p32_in_b = rb[31:0]; p32_in_cin = rcin; p32_in_sub = rsub;
      p8_in_valid  = 1'b1; p8_in_a  = ra[7:0];  p8_in_b  = rb[7:0];  p8_in_cin  = rcin; p8_in_sub  = rsub;
      p64_in_valid = 1'b1; p64_in_a = ra;       p64_in_b = rb;       p64_in_cin = rcin; p64_in_sub = rsub;
      @(negedge clk); #1;
      if (!(p32_in_ready && p8_in_ready && p64_in_ready)) stall++;
    end
    check("stream_stalls", 67'(stall), 67'(0));
    check("p32_stream_rate", 67'(p32_nout - s32), 67'(96));
    check("p8_stream_rate",  67'(p8_nout - s8),   67'(99));
    check("p64_stream_rate", 67'(p64_nout - s64), 67'(92));
    @(posedge clk); #1;
    p32_in_valid = 1'b0; p8_in_valid = 1'b0; p64_in_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (q32.size() == 0 && q8.size() == 0 && q64.size() == 0) break;
    end
    check("stream_drained", 67'(q32.size() + q8.size() + q64.size()), 67'(0));
    check("stream_total", 67'({p32_nout - s32, p8_nout - s8, p64_nout - s64}), 67'({32'd100, 32'd100, 32'd100}));

    // Backpressure: only STAGES beats fit, output held stable
    acc = 0; held = 32'd0;
    s32 = p32_nout;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      p32_out_ready = 1'b0;
      p32_in_valid  = 1'b1; p32_in_a = $urandom; p32_in_b = $urandom;
      p32_in_cin = 1'($urandom_range(0, 1)); p32_in_sub = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      if (p32_in_valid && p32_in_ready) acc++;
      if (i == 4) held = p32_out_sum;
    end
    check("bp_accepted", 67'(acc), 67'(4));
    check("bp_in_ready_low", 67'(p32_in_ready), 67'(0));
    check("bp_out_valid", 67'(p32_out_valid), 67'(1));
    check("bp_sum_stable", 67'(p32_out_sum), 67'(held));
    @(posedge clk); #1;
    p32_in_valid = 1'b0; p32_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (q32.size() == 0) break;
    end
    check("bp_drained", 67'(q32.size()), 67'(0));
    check("bp_released", 67'(p32_nout - s32), 67'(4));

    // Reset with beats in flight
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      p32_out_ready = 1'b0;
      p32_in_valid = 1'b1; p32_in_a = 32'(i + 1); p32_in_b = 32'h0000_0100; p32_in_cin = 1'b0; p32_in_sub = 1'b0;
    end
    @(posedge clk); #1;
    p32_in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_out_valid", 67'(p32_out_valid), 67'(1));
    rst_n = 1'b0;
    #1;
    check("rst_outputs_zero", {31'd0, p32_out_valid, p32_out_sum, p32_out_cout, p32_out_ovf, p32_out_zero}, 67'(0));
    check("rst_in_ready", 67'(p32_in_ready), 67'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    p32_out_ready = 1'b1;
    s32 = p32_nout;
    repeat (8) @(posedge clk);
    #1;
    check("rst_no_stale_beats", 67'(p32_nout - s32), 67'(0));
    check("rst_no_stale_valid", 67'(p32_out_valid), 67'(0));
    op32("after_reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, r32(32'h2345_6789, 1'b0, 1'b0, 1'b0));

    repeat (2) @(posedge clk);
    #1;
    check("final_queues_empty", 67'(q32.size() + q8.size() + q64.size()), 67'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_n_bit.md
# pipelined_adder_n_bit

Parametrised, pipelined integer adder/subtractor, the successor to the fixed 32-bit ripple adder. It splits a WIDTH-bit add into STAGES chunks, one per pipeline stage, and passes the carry between stage registers. Results carry the usual flags and move through valid/ready handshakes at both ends. It is the ALU add path and address-calc adder for the pipelined datapath.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of STAGES.
- STAGES, 4: pipeline depth; chunk width CW = WIDTH/STAGES; STAGES ≥ 1.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry/borrow in.
- in_sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry out of MSB.
- out_ovf  out  1  signed overflow.
- out_zero  out  1  out_sum == 0.

## Operation
- Effective operands: B' = in_sub ? ~in_b : in_b. Effective carry c0 = in_cin ^ in_sub.
  - Add: A+B+cin.
  - Sub with cin=0: A−B. Sub with cin=1: A−B−1.
- Stage k (0..STAGES−1) adds chunk k, bits [k·CW +: CW], of A and B', plus the carry registered by stage k−1 (c0 for stage 0).
- Each stage register holds:
  - valid bit;
  - completed low sum chunks, bits 0..k;
  - unconsumed upper chunks of A and B';
  - carry out of chunk k;
  - carry into MSB (captured only in the last stage).
- out_cout = carry out of the MSB, raw. In subtract, 1 means no borrow.
- out_ovf = carry into MSB XOR carry out of MSB.
- out_zero is computed from the final sum in the last stage and registered with it.
- Handshake, per stage k:
  - adv_k = valid_k && (k==last ? out_ready : (!valid_{k+1} || adv_{k+1})).
  - Stage k loads from stage k−1 (or input) when !valid_k || adv_k.
  - in_ready = !valid_0 || adv_0.
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Pipeline holds up to STAGES results. Throughput is one op per cycle while out_ready is high.
- Registers of a stage that does not load hold their value, including while valid is 0. Output data is stable while out_valid && !out_ready.
- STAGES == 1 degenerates to a single registered full-width adder with the same handshake.
- Only valid bits need reset for correctness. Data/flag registers also reset to 0 so outputs are defined.

## Timing
- Reset (rst_n low, async): all valid bits 0.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0.
  - in_ready=1 from the first edge after deassert. Combinationally it is already 1 during reset.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES−1 (STAGES register stages, first load at edge t). With STAGES=4 it is visible in cycle t+3 after the accept edge.
- in_ready is combinational from out_ready through the adv chain. There is no combinational path from in_* data to out_*.
- Simultaneous accept and release in a full pipeline: allowed. Occupancy stays STAGES.
- Reset mid-operation: all in-flight beats are dropped, no output beat is produced for them, and accept resumes after deassert.
- Critical path: one CW-bit ripple plus the handshake chain.

## Test plan
- WIDTH=32, STAGES=4. Add 0xFFFFFFFF + 0x00000001, cin=0 → after latency: sum=0x00000000, cout=1, zero=1, ovf=0.
- Add 0x7FFFFFFF + 0x00000001 → sum=0x80000000, ovf=1, cout=0. Add 0x0000FFFF + 0x00000001, cin=1 → sum=0x00010001, checking carry across a chunk boundary.
- Sub 5 − 7, cin=0 → sum=0xFFFFFFFE, cout=0, ovf=0. Sub 0x80000000 − 1 → sum=0x7FFFFFFF, ovf=1, cout=1.
- Streaming 100 random ops with out_ready=1 → one result per cycle, in order, matching the reference model.
- Backpressure: out_ready=0 with in_valid=1 continuously → exactly 4 beats accepted, then in_ready=0; out_sum stays stable. Raise out_ready → results drain in order with no loss or duplication.
- Pull rst_n low with 3 beats in flight → out_valid=0 and all outputs 0 immediately. After release, no stale beats emerge and the first new op returns correctly.
- Repeat the random stream with WIDTH=8, STAGES=1 and WIDTH=64, STAGES=8 → results match the reference model.
